// File: rtl/fp_pipe_ctrl_if.sv
// Host-side control bus of the FP MAC pipeline run controller.
//   start/abort/instr_count : requests from the host register block
//   pipe_en/pipe_clr        : pipeline/PC enable and clear
//   host_gnt/busy/done/...  : ownership and run status back to the host
//   state_dbg               : current controller state, for debug visibility
// Handshake: no valid/ready pair. start and abort are single-cycle pulses
// sampled on the rising clock edge; start is accepted only while the
// controller is in IDLE or DONE (host_gnt=1), and abort only while it is in
// CLEAR, RUN or DRAIN (busy=1). Requests outside those windows are dropped.
interface fp_pipe_ctrl_if #(
  parameter int CNT_W = 13
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] instr_count;
  logic             pipe_en;
  logic             pipe_clr;
  logic             host_gnt;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [15:0]      cycle_count;
  logic [2:0]       state_dbg;

  modport master (
    output start, abort, instr_count,
    input  pipe_en, pipe_clr, host_gnt, busy, done, aborted, cycle_count, state_dbg
  );

  modport slave (
    input  start, abort, instr_count,
    output pipe_en, pipe_clr, host_gnt, busy, done, aborted, cycle_count, state_dbg
  );
endinterface

// File: rtl/fp_pipe_ctrl.sv
// Run controller for the FP MAC pipeline: takes imem/dmem ownership from the
// host, pulses a pipeline clear, holds pipe_en for instr_count + DRAIN_CYCLES
// cycles, then hands the memories back and reports done (or aborted).
// Optional feature macro: FP_PIPE_CTRL_PERF_EN builds the enabled-cycle
// counter; without it cycle_count is tied to 0.
module fp_pipe_ctrl #(
  parameter int CNT_W        = 13,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic           clk,
  input  logic           reset,
  fp_pipe_ctrl_if.slave  ctl
);

  localparam int DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [DRN_W-1:0] drain_cnt;
  logic             start_acc;
  logic             abort_acc;
  logic             last_instr;

  logic             pipe_en_q;
  logic             pipe_clr_q;
  logic             host_gnt_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  assign start_acc  = ctl.start && (state == S_IDLE || state == S_DONE);
  assign abort_acc  = ctl.abort && (state == S_CLEAR || state == S_RUN || state == S_DRAIN);
  assign last_instr = (state == S_RUN) && (remaining == CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; abort outranks every other transition while busy.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (ctl.start) state_nxt = (ctl.instr_count != '0) ? S_CLEAR : S_DONE;
      end
      S_CLEAR: begin
        state_nxt = ctl.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (ctl.abort)       state_nxt = S_IDLE;
        else if (last_instr) state_nxt = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (ctl.abort)                     state_nxt = S_IDLE;
        else if (drain_cnt == DRN_W'(1))   state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue and drain countdowns; the instruction count is captured on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_acc)             remaining <= ctl.instr_count;
      else if (state == S_RUN)   remaining <= remaining - CNT_W'(1);
      if (last_instr)            drain_cnt <= DRN_W'(DRAIN_CYCLES);
      else if (state == S_DRAIN) drain_cnt <= drain_cnt - DRN_W'(1);
    end
  end

  // Outputs are flops loaded from the decoded next state, so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_en_q  <= 1'b0;
      pipe_clr_q <= 1'b0;
      host_gnt_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pipe_en_q  <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      pipe_clr_q <= (state_nxt == S_CLEAR);
      host_gnt_q <= (state_nxt == S_IDLE) || (state_nxt == S_DONE);
      busy_q     <= (state_nxt == S_CLEAR) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done_q     <= (state_nxt == S_DONE);
    end
  end

  // Sticky abort flag, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (reset)          aborted_q <= 1'b0;
    else if (start_acc) aborted_q <= 1'b0;
    else if (abort_acc) aborted_q <= 1'b1;
  end

`ifdef FP_PIPE_CTRL_PERF_EN
  logic [15:0] cycle_cnt;

  // Saturating count of enabled cycles; zeroed on each accepted start, held otherwise.
  always_ff @(posedge clk) begin
    if (reset)                                    cycle_cnt <= '0;
    else if (start_acc)                           cycle_cnt <= '0;
    else if (pipe_en_q && cycle_cnt != 16'hFFFF)  cycle_cnt <= cycle_cnt + 16'd1;
  end

  assign ctl.cycle_count = cycle_cnt;
`else
  assign ctl.cycle_count = 16'd0;
`endif

  assign ctl.pipe_en   = pipe_en_q;
  assign ctl.pipe_clr  = pipe_clr_q;
  assign ctl.host_gnt  = host_gnt_q;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.aborted   = aborted_q;
  assign ctl.state_dbg = state;

endmodule

// File: tb/tb_fp_pipe_ctrl.sv
// Testbench for fp_pipe_ctrl: directed scenarios plus randomized runs checked
// against a cycle-position model of a run (clear at offset 1, enable for
// count+drain cycles, then done/idle).
module tb_fp_pipe_ctrl;

  localparam int CNT_W = 13;
  localparam int DRAIN = 8;
`ifdef FP_PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [15:0] exp_q[$];

  fp_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();
  fp_pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (.clk(clk), .reset(reset), .ctl(bus));

  fp_pipe_ctrl_if #(.CNT_W(CNT_W)) bus_s ();
  fp_pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(65535)) dut_s (.clk(clk), .reset(reset), .ctl(bus_s));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected cycle_count after a given number of enabled cycles.
  function automatic logic [15:0] cc_model(input int en_cycles);
    if (!PERF) return 16'd0;
    return (en_cycles > 65535) ? 16'hFFFF : 16'(en_cycles);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({bus.pipe_en, bus.pipe_clr, bus.host_gnt, bus.busy, bus.done, bus.aborted} !== 6'b001000) begin
      failures++;
      $display("FAIL reset_flags: got en/clr/gnt/busy/done/abt=%b required 001000",
               {bus.pipe_en, bus.pipe_clr, bus.host_gnt, bus.busy, bus.done, bus.aborted});
    end
    checks++;
    if (bus.cycle_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_cycle_count: got %0d required 0", bus.cycle_count);
    end
  endtask

  // Drives one run and checks every cycle against the position within the run.
  // abort_at: pulse abort during the Nth enabled cycle (0 = none).
  // restart_at: pulse a fresh start during the Nth enabled cycle (0 = none).
  task automatic run_program(input int n, input int abort_at, input int restart_at, input string tag);
    int en_exp;
    int en_seen;
    bit ab;
    logic [15:0] cc_exp;
    ab      = (abort_at != 0);
    en_exp  = ab ? abort_at : n + DRAIN;
    en_seen = 0;
    exp_q.push_back(cc_model(en_exp));
    bus.instr_count = CNT_W'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.instr_count = CNT_W'($urandom_range(0, 8191));
    for (int k = 1; k <= en_exp + 1; k++) begin
      checks++;
      if (bus.pipe_clr !== (k == 1) || bus.pipe_en !== (k >= 2) || bus.host_gnt !== 1'b0 ||
          bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL %s_cycle%0d: got clr/en/gnt/busy/done=%b%b%b%b%b required %b%b001 0",
                 tag, k, bus.pipe_clr, bus.pipe_en, bus.host_gnt, bus.busy, bus.done, k == 1, k >= 2);
      end
      cc_exp = cc_model((k >= 2) ? k - 2 : 0);
      checks++;
      if (bus.cycle_count !== cc_exp) begin
        failures++;
        $display("FAIL %s_cc_cycle%0d: got %0d required %0d", tag, k, bus.cycle_count, cc_exp);
      end
      if (bus.pipe_en) en_seen++;
      bus.abort = ab && (k - 1 == abort_at);
      bus.start = (restart_at != 0) && (k - 1 == restart_at);
      tick();
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (en_seen !== en_exp) begin
      failures++;
      $display("FAIL %s_en_len: got %0d required %0d", tag, en_seen, en_exp);
    end
    checks++;
    if ({bus.pipe_en, bus.pipe_clr, bus.host_gnt, bus.busy, bus.done, bus.aborted} !== {4'b0010, !ab, ab}) begin
      failures++;
      $display("FAIL %s_end_flags: got en/clr/gnt/busy/done/abt=%b required %b", tag,
               {bus.pipe_en, bus.pipe_clr, bus.host_gnt, bus.busy, bus.done, bus.aborted}, {4'b0010, !ab, ab});
    end
    cc_exp = exp_q.pop_front();
    checks++;
    if (bus.cycle_count !== cc_exp) begin
      failures++;
      $display("FAIL %s_end_cc: got %0d required %0d", tag, bus.cycle_count, cc_exp);
    end
  endtask

  task automatic test_basic();
    run_program(5, 0, 0, "basic5");
  endtask

  task automatic test_zero_count();
    bus.instr_count = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.pipe_en, bus.pipe_clr, bus.host_gnt, bus.busy, bus.done, bus.aborted} !== 6'b001010) begin
        failures++;
        $display("FAIL zero_count_cycle%0d: got en/clr/gnt/busy/done/abt=%b required 001010", k,
                 {bus.pipe_en, bus.pipe_clr, bus.host_gnt, bus.busy, bus.done, bus.aborted});
      end
      tick();
    end
    checks++;
    if (bus.cycle_count !== 16'd0) begin
      failures++;
      $display("FAIL zero_count_cc: got %0d required 0", bus.cycle_count);
    end
  endtask

  task automatic test_abort();
    run_program(100, 20, 0, "abort100");
    tick();
    checks++;
    if (bus.aborted !== 1'b1 || bus.done !== 1'b0 || bus.host_gnt !== 1'b1) begin
      failures++;
      $display("FAIL abort_hold: got abt/done/gnt=%b%b%b required 101", bus.aborted, bus.done, bus.host_gnt);
    end
  endtask

  task automatic test_ignored_requests();
    run_program(10, 0, 4, "restart_ignored");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.aborted !== 1'b0 || bus.host_gnt !== 1'b1 || bus.pipe_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_done: got done/abt/gnt/en=%b%b%b%b required 1010",
               bus.done, bus.aborted, bus.host_gnt, bus.pipe_en);
    end
    checks++;
    if (bus.cycle_count !== cc_model(10 + DRAIN)) begin
      failures++;
      $display("FAIL abort_in_done_cc: got %0d required %0d", bus.cycle_count, cc_model(10 + DRAIN));
    end
  endtask

  task automatic test_reset_in_drain();
    bus.instr_count = CNT_W'(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 9; k++) tick();
    checks++;
    if (bus.pipe_en !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_drain: got en/busy=%b%b required 11", bus.pipe_en, bus.busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.pipe_en, bus.pipe_clr, bus.host_gnt, bus.busy, bus.done, bus.aborted} !== 6'b001000 ||
        bus.cycle_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_in_drain: got flags=%b cc=%0d required 001000 cc=0",
               {bus.pipe_en, bus.pipe_clr, bus.host_gnt, bus.busy, bus.done, bus.aborted}, bus.cycle_count);
    end
    tick();
    checks++;
    if (bus.pipe_clr !== 1'b0 || bus.host_gnt !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_idle: got clr/gnt=%b%b required 01", bus.pipe_clr, bus.host_gnt);
    end
    run_program(3, 0, 0, "after_reset3");
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 12; r++) begin
      int n;
      int a;
      n = $urandom_range(1, 40);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + DRAIN) : 0;
      run_program(n, a, 0, "random");
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
  endtask

  task automatic test_saturation();
`ifdef FP_PIPE_CTRL_PERF_EN
    int en_seen;
    int cyc;
    bus_s.instr_count = CNT_W'(4096);
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    en_seen = 0;
    cyc = 0;
    while (bus_s.done !== 1'b1 && cyc < 70100) begin
      if (bus_s.pipe_en && bus_s.host_gnt) begin
        checks++;
        failures++;
        $display("FAIL sat_gnt_en_overlap: got gnt=1 en=1 required not both");
      end
      if (bus_s.pipe_en) en_seen++;
      tick();
      cyc++;
    end
    checks++;
    if (bus_s.done !== 1'b1) begin
      failures++;
      $display("FAIL sat_done_timeout: got done=%b after %0d cycles required 1", bus_s.done, cyc);
    end
    checks++;
    if (en_seen !== 69631) begin
      failures++;
      $display("FAIL sat_en_len: got %0d required 69631", en_seen);
    end
    checks++;
    if (bus_s.cycle_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_cc: got %0h required ffff", bus_s.cycle_count);
    end
`endif
  endtask

  // Global invariant: the host and the pipeline never own the memories together.
  always @(negedge clk) begin
    if (!reset && bus.host_gnt === 1'b1 && bus.pipe_en === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL gnt_en_overlap: got gnt=1 en=1 required not both");
    end
  end

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.instr_count = '0;
    bus_s.start = 1'b0;
    bus_s.abort = 1'b0;
    bus_s.instr_count = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_abort();
    test_ignored_requests();
    test_reset_in_drain();
    test_random_runs();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_pipe_ctrl.md
# fp_pipe_ctrl

Run controller for the FP MAC pipeline. It takes ownership of the instruction and data memories from the host, clears and starts the pipeline, and holds `pipe_en` for exactly the program length plus the pipeline drain. It then returns memory ownership to the host and flags completion. It sits between the host register interface and the pipeline's `pipe_en` and memory-access muxes.

## Interface
Parameters:
- `CNT_W`, 13: width of the instruction count; supports up to 4096 instructions.
- `DRAIN_CYCLES`, 8: cycles `pipe_en` stays high after the last instruction issue, so the final result reaches encoded memory.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to run the loaded program.
- `abort`  in  1  terminate the current run.
- `instr_count`  in  CNT_W  number of instructions to issue; sampled on an accepted `start`.
- `pipe_en`  out  1  pipeline/PC enable.
- `pipe_clr`  out  1  one-cycle clear pulse to the PC counter and pipeline stage registers.
- `host_gnt`  out  1  host may drive imem/dmem external read/write ports.
- `busy`  out  1  run in progress.
- `done`  out  1  last run completed normally; level signal.
- `aborted`  out  1  last run ended by `abort`; level signal.
- `cycle_count`  out  16  enabled cycles in the last or current run.

## Operation
- All outputs are registered and decoded from the state (Moore).
- States and outputs:
  - IDLE: `host_gnt`=1.
  - CLEAR: `pipe_clr`=1, `busy`=1.
  - RUN: `pipe_en`=1, `busy`=1.
  - DRAIN: `pipe_en`=1, `busy`=1.
  - DONE: `host_gnt`=1, `done`=1.
- Transitions:
  - IDLE/DONE, on `start` with `instr_count`≠0 → CLEAR. The count is latched into `remaining`, `done` and `aborted` are cleared, and `cycle_count` is zeroed.
  - IDLE/DONE, on `start` with `instr_count`=0 → DONE. `done` is set and `pipe_en` never asserts.
  - CLEAR → RUN, unconditionally, after one cycle.
  - RUN: `remaining` decrements each cycle. When `remaining`=1 → DRAIN, with the drain counter loaded to `DRAIN_CYCLES`.
  - DRAIN: decrement each cycle. When the drain counter is 1 → DONE.
  - CLEAR/RUN/DRAIN, on `abort` → IDLE next cycle, with `aborted`=1. `abort` has priority over all other transitions.
- `start` is ignored in CLEAR/RUN/DRAIN. `abort` is ignored in IDLE/DONE.
- The program image must be followed by `DRAIN_CYCLES` no-op words (wEn=0, valid=0). The controller does not gate fetch during DRAIN.
- `cycle_count` increments on every cycle with `pipe_en`=1 and saturates at 0xFFFF. It holds its value in IDLE/DONE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `pipe_en`=0, `pipe_clr`=0, `host_gnt`=1, `busy`=0, `done`=0, `aborted`=0, `cycle_count`=0.
- For `start` sampled at edge t:
  - `host_gnt`=0 and `pipe_clr`=1 from t+1.
  - `pipe_en`=1 from t+2 for exactly `instr_count`+`DRAIN_CYCLES` cycles.
  - `done`=1 and `host_gnt`=1 at edge t+2+`instr_count`+`DRAIN_CYCLES`.
- `abort` sampled at edge t: `pipe_en`=0, `busy`=0, `host_gnt`=1 and `aborted`=1 from t+1.
- `reset` mid-run: all outputs return to their reset values on the next edge. No `pipe_clr` pulse is issued.
- `host_gnt` and `pipe_en` are never both 1 in the same cycle.

## Configuration
- Macro `FP_PIPE_CTRL_PERF_EN`.
- Defined: the `cycle_count` counter is implemented as described above.
- Undefined: no counter logic is built and `cycle_count` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then `start` with `instr_count`=5 and `DRAIN_CYCLES`=8:
  - `pipe_clr` high for 1 cycle, then `pipe_en` high for 13 consecutive cycles.
  - `done`=1 and `host_gnt`=1 on the following edge.
  - `cycle_count`=13 (0 with the macro undefined).
- `start` with `instr_count`=0 → `done`=1 next cycle; `pipe_en` and `pipe_clr` never assert; `host_gnt` stays 1.
- `start` with `instr_count`=100; `abort` on the 20th `pipe_en` cycle → IDLE next cycle, `aborted`=1, `done`=0, `cycle_count`=20.
- `start` re-pulsed during RUN, and `abort` pulsed in DONE → both ignored; the run length is unchanged and `done` stays 1.
- `reset` asserted during DRAIN → all outputs at their reset values next cycle. A subsequent `start` with count 3 produces 11 `pipe_en` cycles.
- With `FP_PIPE_CTRL_PERF_EN` defined, `instr_count`=4096 and `DRAIN_CYCLES` overridden to 65535 → `cycle_count` saturates at 0xFFFF and `done` still asserts after 69631 enabled cycles.
